// File: rtl/alu_sequencer.sv
// alu_sequencer: control-side partner of the ALU. Accepts one instruction at a
// time, fetches its two register operands, drives the ALU, waits ALU_WAIT
// cycles, then performs a register writeback or resolves a BEQ/BNE branch.
// Owns the program counter. Pulses (wb_en/branch_taken/illegal_op) appear on
// the cycle after DONE, i.e. ALU_WAIT+2 cycles after the accepting edge.
module alu_sequencer #(
    parameter int PC_W     = 8,
    parameter int ALU_WAIT = 1
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [31:0]     instr,
    input  logic            instr_valid,
    output logic            instr_ready,
    output logic [4:0]      rs_addr,
    output logic [4:0]      rt_addr,
    input  logic [31:0]     rs_data,
    input  logic [31:0]     rt_data,
    output logic [4:0]      alu_opcode,
    output logic [31:0]     alu_a,
    output logic [31:0]     alu_b,
    input  logic [31:0]     alu_out,
    input  logic            alu_zero,
    output logic            wb_en,
    output logic [4:0]      wb_addr,
    output logic [31:0]     wb_data,
    output logic            branch_taken,
    output logic            illegal_op,
    output logic [PC_W-1:0] pc
);

    localparam int         CNT_W    = (ALU_WAIT > 1) ? $clog2(ALU_WAIT) : 1;
    localparam logic [4:0] OP_BEQ   = 5'b00010;
    localparam logic [4:0] OP_BNE   = 5'b00111;
    localparam logic [4:0] OP_PASSA = 5'b10101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic             ready_q, ready_d;
    logic [4:0]       op_q, op_d;
    logic [4:0]       rd_q, rd_d;
    logic [11:0]      imm_q, imm_d;
    logic [4:0]       rs_addr_q, rs_addr_d;
    logic [4:0]       rt_addr_q, rt_addr_d;
    logic [4:0]       alu_opcode_q, alu_opcode_d;
    logic [31:0]      alu_a_q, alu_a_d;
    logic [31:0]      alu_b_q, alu_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      res_q, res_d;
    logic             zero_q, zero_d;
    logic             wb_en_q, wb_en_d;
    logic [4:0]       wb_addr_q, wb_addr_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic             branch_q, branch_d;
    logic             illegal_q, illegal_d;
    logic [PC_W-1:0]  pc_q, pc_d;

    logic             accept_s;
    logic [PC_W-1:0]  imm_pc_s;

    // BEQ and BNE are the only ops that resolve a branch from the zero flag.
    function automatic logic is_compare(input logic [4:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

    // Opcodes 01010..01111 have no ALU meaning and must never reach the ALU.
    function automatic logic is_illegal(input logic [4:0] op);
        return (op[4:3] == 2'b01) && (op[2:0] >= 3'b010);
    endfunction

    assign accept_s = (state_q == S_IDLE) && ready_q && instr_valid;
    // Sign-extend (or truncate) the offset to PC width so backward branches wrap.
    assign imm_pc_s = PC_W'($signed(imm_q));

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> READ -> EXEC (ALU_WAIT cycles) -> DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = S_READ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: state_d = S_EXEC;
            S_EXEC: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output/datapath next values for the current state.
    always_comb begin
        ready_d      = (state_d == S_IDLE);
        op_d         = op_q;
        rd_d         = rd_q;
        imm_d        = imm_q;
        rs_addr_d    = rs_addr_q;
        rt_addr_d    = rt_addr_q;
        alu_opcode_d = alu_opcode_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        cnt_d        = cnt_q;
        res_d        = res_q;
        zero_d       = zero_q;
        wb_en_d      = 1'b0;
        wb_addr_d    = wb_addr_q;
        wb_data_d    = wb_data_q;
        branch_d     = 1'b0;
        illegal_d    = 1'b0;
        pc_d         = pc_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    op_d      = instr[31:27];
                    rd_d      = instr[26:22];
                    rs_addr_d = instr[21:17];
                    rt_addr_d = instr[16:12];
                    imm_d     = instr[11:0];
                end else begin
                    op_d = op_q;
                end
            end
            S_READ: begin
                alu_a_d = rs_data;
                alu_b_d = rt_data;
                cnt_d   = CNT_W'(ALU_WAIT - 1);
                if (is_illegal(op_q)) begin
                    alu_opcode_d = OP_PASSA;
                end else begin
                    alu_opcode_d = op_q;
                end
            end
            S_EXEC: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    res_d  = alu_out;
                    zero_d = alu_zero;
                end else begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            S_DONE: begin
                if (is_compare(op_q)) begin
                    branch_d = zero_q;
                    if (zero_q) begin
                        pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1} + imm_pc_s;
                    end else begin
                        pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
                    end
                end else if (is_illegal(op_q)) begin
                    illegal_d = 1'b1;
                    pc_d      = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
                end else begin
                    wb_en_d   = 1'b1;
                    wb_addr_d = rd_q;
                    wb_data_d = res_q;
                    pc_d      = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                ready_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; reset discards any in-flight instruction.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ready_q      <= 1'b0;
            op_q         <= 5'd0;
            rd_q         <= 5'd0;
            imm_q        <= 12'd0;
            rs_addr_q    <= 5'd0;
            rt_addr_q    <= 5'd0;
            alu_opcode_q <= 5'd0;
            alu_a_q      <= 32'd0;
            alu_b_q      <= 32'd0;
            cnt_q        <= {CNT_W{1'b0}};
            res_q        <= 32'd0;
            zero_q       <= 1'b0;
            wb_en_q      <= 1'b0;
            wb_addr_q    <= 5'd0;
            wb_data_q    <= 32'd0;
            branch_q     <= 1'b0;
            illegal_q    <= 1'b0;
            pc_q         <= {PC_W{1'b0}};
        end else begin
            ready_q      <= ready_d;
            op_q         <= op_d;
            rd_q         <= rd_d;
            imm_q        <= imm_d;
            rs_addr_q    <= rs_addr_d;
            rt_addr_q    <= rt_addr_d;
            alu_opcode_q <= alu_opcode_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            cnt_q        <= cnt_d;
            res_q        <= res_d;
            zero_q       <= zero_d;
            wb_en_q      <= wb_en_d;
            wb_addr_q    <= wb_addr_d;
            wb_data_q    <= wb_data_d;
            branch_q     <= branch_d;
            illegal_q    <= illegal_d;
            pc_q         <= pc_d;
        end
    end

    assign instr_ready  = ready_q;
    assign rs_addr      = rs_addr_q;
    assign rt_addr      = rt_addr_q;
    assign alu_opcode   = alu_opcode_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign wb_en        = wb_en_q;
    assign wb_addr      = wb_addr_q;
    assign wb_data      = wb_data_q;
    assign branch_taken = branch_q;
    assign illegal_op   = illegal_q;
    assign pc           = pc_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer (PC_W=8, ALU_WAIT=1). A behavioural register
// file and ALU surround the DUT; expected values are hand-computed constants.
module tb_alu_sequencer;

    logic        clock;
    logic        reset_n;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [4:0]  alu_opcode;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        branch_taken;
    logic        illegal_op;
    logic [7:0]  pc;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] regs [0:31];

    alu_sequencer #(.PC_W(8), .ALU_WAIT(1)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .alu_opcode  (alu_opcode),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_out     (alu_out),
        .alu_zero    (alu_zero),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .branch_taken(branch_taken),
        .illegal_op  (illegal_op),
        .pc          (pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register file: combinational read.
    assign rs_data = regs[rs_addr];
    assign rt_data = regs[rt_addr];

    // Minimal ALU: add, sub, pass-a, compares; anything else xor.
    always_comb begin
        case (alu_opcode)
            5'b00000: alu_out = alu_a + alu_b;
            5'b00001: alu_out = alu_a - alu_b;
            5'b10101: alu_out = alu_a;
            default:  alu_out = alu_a ^ alu_b;
        endcase
        case (alu_opcode)
            5'b00010: alu_zero = (alu_a == alu_b);
            5'b00111: alu_zero = (alu_a != alu_b);
            default:  alu_zero = 1'b0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [11:0] imm);
        return {op, rd, rs, rt, imm};
    endfunction

    // Present an instruction once ready is seen, return 1 ns after the accepting edge.
    task automatic issue(input logic [31:0] ins, input logic keep);
        int waited;
        waited = 0;
        @(negedge clock);
        while (!instr_ready && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        if (waited >= 20) chk("ready_timeout", 32'(instr_ready), 32'd1);
        instr       = ins;
        instr_valid = 1'b1;
        @(posedge clock);
        #1;
        if (!keep) instr_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int wb_cnt;
        int wb_at [0:3];

        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        regs[1] = 32'd5;
        regs[2] = 32'd7;
        regs[4] = 32'd9;
        regs[5] = 32'd9;
        reset_n     = 1'b0;
        instr       = 32'd0;
        instr_valid = 1'b0;

        // Reset state
        #12;
        chk("rst_ready", 32'(instr_ready), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_wb_en", 32'(wb_en), 32'd0);
        chk("rst_opcode", 32'(alu_opcode), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // 1: add r3 = r1 + r2
        issue(enc(5'b00000, 5'd3, 5'd1, 5'd2, 12'd0), 1'b0);
        chk("add_rs_addr", 32'(rs_addr), 32'd1);
        chk("add_rt_addr", 32'(rt_addr), 32'd2);
        chk("add_busy", 32'(instr_ready), 32'd0);
        step();
        chk("add_alu_a", alu_a, 32'd5);
        chk("add_alu_b", alu_b, 32'd7);
        chk("add_opcode", 32'(alu_opcode), 32'd0);
        step();
        chk("add_wb_early", 32'(wb_en), 32'd0);
        step();
        chk("add_wb_en", 32'(wb_en), 32'd1);
        chk("add_wb_addr", 32'(wb_addr), 32'd3);
        chk("add_wb_data", wb_data, 32'd12);
        chk("add_branch", 32'(branch_taken), 32'd0);
        chk("add_pc", 32'(pc), 32'd1);
        step();
        chk("add_wb_pulse", 32'(wb_en), 32'd0);

        // 2: beq taken, imm +4, pc 1 -> 6
        issue(enc(5'b00010, 5'd0, 5'd4, 5'd5, 12'd4), 1'b0);
        repeat (3) step();
        chk("beq_taken", 32'(branch_taken), 32'd1);
        chk("beq_no_wb", 32'(wb_en), 32'd0);
        chk("beq_pc", 32'(pc), 32'd6);
        step();
        chk("beq_pulse", 32'(branch_taken), 32'd0);

        // 3: bne not taken, imm -3, pc 6 -> 7
        issue(enc(5'b00111, 5'd0, 5'd4, 5'd5, 12'hFFD), 1'b0);
        repeat (3) step();
        chk("bne_branch", 32'(branch_taken), 32'd0);
        chk("bne_no_wb", 32'(wb_en), 32'd0);
        chk("bne_pc", 32'(pc), 32'd7);

        // 5: illegal op, ALU sees pass-a, pc 7 -> 8
        issue(enc(5'b01100, 5'd9, 5'd1, 5'd2, 12'd0), 1'b0);
        step();
        chk("ill_opcode", 32'(alu_opcode), 32'h15);
        repeat (2) step();
        chk("ill_pulse", 32'(illegal_op), 32'd1);
        chk("ill_no_wb", 32'(wb_en), 32'd0);
        chk("ill_no_br", 32'(branch_taken), 32'd0);
        chk("ill_pc", 32'(pc), 32'd8);
        step();
        chk("ill_pulse_end", 32'(illegal_op), 32'd0);

        // 6: reset during EXEC
        issue(enc(5'b00000, 5'd6, 5'd1, 5'd2, 12'd0), 1'b0);
        step();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_pc", 32'(pc), 32'd0);
        chk("mid_rst_alu_a", alu_a, 32'd0);
        chk("mid_rst_ready", 32'(instr_ready), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        wb_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (wb_en) wb_cnt++;
        end
        chk("mid_rst_no_wb", 32'(wb_cnt), 32'd0);

        // 4: backward wrap, pc 0 + 1 - 2 -> 255
        issue(enc(5'b00010, 5'd0, 5'd4, 5'd5, 12'hFFE), 1'b0);
        repeat (3) step();
        chk("wrap_taken", 32'(branch_taken), 32'd1);
        chk("wrap_pc", 32'(pc), 32'd255);

        // sub r7 = r2 - r1, pc 255 -> 0
        issue(enc(5'b00001, 5'd7, 5'd2, 5'd1, 12'd0), 1'b0);
        repeat (3) step();
        chk("sub_wb_data", wb_data, 32'd2);
        chk("sub_wb_addr", 32'(wb_addr), 32'd7);
        chk("sub_pc_wrap", 32'(pc), 32'd0);

        // Throughput: instr_valid held high, writebacks every 4 cycles
        issue(enc(5'b00000, 5'd3, 5'd1, 5'd2, 12'd0), 1'b1);
        wb_cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (wb_en) begin
                if (wb_cnt < 4) wb_at[wb_cnt] = i;
                wb_cnt++;
            end
        end
        instr_valid = 1'b0;
        chk("tp_wb_count", 32'(wb_cnt), 32'd3);
        if (wb_cnt == 3) begin
            chk("tp_first", 32'(wb_at[0]), 32'd3);
            chk("tp_gap1", 32'(wb_at[1] - wb_at[0]), 32'd4);
            chk("tp_gap2", 32'(wb_at[2] - wb_at[1]), 32'd4);
        end
        chk("tp_pc", 32'(pc), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
